// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types for the binary/Gray counter family.
package gray_pkg;

  // Widest counter the helper functions can service; callers cast in and out.
  localparam int MAX_WIDTH = 64;

  // Action selected for the counter on a given clock edge, in priority order.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_STEP  = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  // Binary to Gray: each bit is the XOR of itself and the next-higher bit.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB downwards. Zero-extended inputs
  // decode correctly for any width up to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // All-ones value of the given width, right-aligned in a MAX_WIDTH word.
  function automatic logic [MAX_WIDTH-1:0] max_val(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder; also suitable for FIFO pointer
// synchronisers that need the binary value of a synchronised Gray pointer.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Decode through the shared helper so every user shares one definition.
  always_comb begin
    bin = WIDTH'(gray2bin(MAX_WIDTH'(gray)));
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter that keeps a binary count and its Gray image in lockstep.
// Both are registered from the same next-state value, so gray_q never glitches
// and changes by a single bit on every counting step, including wrap steps.
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter bit               WRAP      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap_p,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX        = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] ZERO       = '0;
  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RESET_VAL)));

  op_t              op;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;
  logic             next_sat;

  gray_to_binary #(
    .WIDTH(WIDTH)
  ) u_load_decode (
    .gray(load_val),
    .bin (load_bin)
  );

  // Resolve the per-edge action: clear beats load beats count beats hold.
  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_STEP;
    end
  end

  // Next count, its Gray image and the flags, all derived from one decision.
  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    next_sat  = sat;
    case (op)
      OP_CLEAR: begin
        next_bin = ZERO;
        next_sat = 1'b0;
      end
      OP_LOAD: begin
        next_bin = load_is_gray ? load_bin : load_val;
        next_sat = 1'b0;
      end
      OP_STEP: begin
        next_sat = 1'b0;
        if (up) begin
          if (bin_q != MAX) begin
            next_bin = bin_q + 1'b1;
          end else if (WRAP) begin
            next_bin  = ZERO;
            next_wrap = 1'b1;
          end else begin
            next_sat = 1'b1;
          end
        end else begin
          if (bin_q != ZERO) begin
            next_bin = bin_q - 1'b1;
          end else if (WRAP) begin
            next_bin  = MAX;
            next_wrap = 1'b1;
          end else begin
            next_sat = 1'b1;
          end
        end
      end
      default: begin
        next_bin = bin_q;
      end
    endcase
    next_gray = WIDTH'(bin2gray(MAX_WIDTH'(next_bin)));
  end

  // Register count, Gray image and flags together on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RESET_VAL;
      gray_q <= RESET_GRAY;
      wrap_p <= 1'b0;
      sat    <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      wrap_p <= next_wrap;
      sat    <= next_sat;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (4-bit wrapping, 4-bit saturating,
// 10-bit wrapping with a non-zero reset value) share one control stream and are
// checked every cycle against an arithmetic model, plus literal expectations.
module tb_gray_counter;

  localparam int NUM = 3;

  typedef struct {
    int cnt;
    bit wrap;
    bit sat;
    bit step;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic       load_is_gray;
  logic [9:0] load_val;
  logic       en;
  logic       up;

  logic [3:0] bin_a, gray_a;
  logic       wrap_a, sat_a;
  logic [3:0] bin_s, gray_s;
  logic       wrap_s, sat_s;
  logic [9:0] bin_w, gray_w;
  logic       wrap_w, sat_w;

  int     checks   = 0;
  int     failures = 0;
  model_t m[NUM];
  int     prev_gray[NUM];
  bit     prev_valid[NUM];

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'h0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val[3:0]), .en(en), .up(up),
    .bin_q(bin_a), .gray_q(gray_a), .wrap_p(wrap_a), .sat(sat_a)
  );

  gray_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'h0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val[3:0]), .en(en), .up(up),
    .bin_q(bin_s), .gray_q(gray_s), .wrap_p(wrap_s), .sat(sat_s)
  );

  gray_counter #(.WIDTH(10), .WRAP(1'b1), .RESET_VAL(10'h155)) dut_wide (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val), .en(en), .up(up),
    .bin_q(bin_w), .gray_q(gray_w), .wrap_p(wrap_w), .sat(sat_w)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic int width_of(input int k);
    return (k == 2) ? 10 : 4;
  endfunction

  function automatic bit wraps(input int k);
    return k != 1;
  endfunction

  function automatic int reset_of(input int k);
    return (k == 2) ? 'h155 : 0;
  endfunction

  function automatic int max_of(input int k);
    return (1 << width_of(k)) - 1;
  endfunction

  function automatic int to_gray(input int n);
    return n ^ (n >> 1);
  endfunction

  // Inverse Gray by exhaustive search over the counter's range.
  function automatic int from_gray(input int g, input int k);
    for (int n = 0; n <= max_of(k); n++) begin
      if (to_gray(n) == g) return n;
    end
    return -1;
  endfunction

  // One clock edge of counter behaviour expressed as plain integer arithmetic.
  function automatic model_t model_next(input int k, input model_t s);
    model_t n;
    int     mx;
    int     v;
    n      = s;
    mx     = max_of(k);
    n.wrap = 1'b0;
    n.step = 1'b0;
    if (clr) begin
      n.cnt = 0;
      n.sat = 1'b0;
    end else if (load) begin
      v     = int'(load_val) & mx;
      n.cnt = load_is_gray ? from_gray(v, k) : v;
      n.sat = 1'b0;
    end else if (en) begin
      if (up && s.cnt < mx) begin
        n.cnt  = s.cnt + 1;
        n.sat  = 1'b0;
        n.step = 1'b1;
      end else if (!up && s.cnt > 0) begin
        n.cnt  = s.cnt - 1;
        n.sat  = 1'b0;
        n.step = 1'b1;
      end else if (wraps(k)) begin
        n.cnt  = up ? 0 : mx;
        n.wrap = 1'b1;
        n.sat  = 1'b0;
        n.step = 1'b1;
      end else begin
        n.sat = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic int act_bin(input int k);
    case (k)
      0:       return int'(bin_a);
      1:       return int'(bin_s);
      default: return int'(bin_w);
    endcase
  endfunction

  function automatic int act_gray(input int k);
    case (k)
      0:       return int'(gray_a);
      1:       return int'(gray_s);
      default: return int'(gray_w);
    endcase
  endfunction

  function automatic int act_wrap(input int k);
    case (k)
      0:       return int'(wrap_a);
      1:       return int'(wrap_s);
      default: return int'(wrap_w);
    endcase
  endfunction

  function automatic int act_sat(input int k);
    case (k)
      0:       return int'(sat_a);
      1:       return int'(sat_s);
      default: return int'(sat_w);
    endcase
  endfunction

  // Single comparison: counts it and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of controls, let the edge happen, return just after the
  // following falling edge so outputs are stable for literal checks.
  task automatic applyStimulus(input logic c, input logic l, input logic lg,
                               input logic [9:0] lv, input logic e, input logic u);
    clr          = c;
    load         = l;
    load_is_gray = lg;
    load_val     = lv;
    en           = e;
    up           = u;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Reference model advances on the same edges as the DUTs, with async reset.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NUM; k++) begin
      if (!rst_n) begin
        m[k] <= '{cnt: reset_of(k), wrap: 1'b0, sat: 1'b0, step: 1'b0};
      end else begin
        m[k] <= model_next(k, m[k]);
      end
    end
  end

  // Every falling edge: compare all outputs of every instance with the model
  // and confirm that counting steps move exactly one Gray bit.
  always @(negedge clk) begin
    for (int k = 0; k < NUM; k++) begin
      checkOutput($sformatf("bin[%0d]", k), act_bin(k), m[k].cnt);
      checkOutput($sformatf("gray[%0d]", k), act_gray(k), to_gray(m[k].cnt));
      checkOutput($sformatf("wrap[%0d]", k), act_wrap(k), int'(m[k].wrap));
      checkOutput($sformatf("sat[%0d]", k), act_sat(k), int'(m[k].sat));
      if (rst_n && prev_valid[k] && m[k].step) begin
        checkOutput($sformatf("onebit[%0d]", k), $countones(act_gray(k) ^ prev_gray[k]), 1);
      end
      prev_gray[k]  <= act_gray(k);
      prev_valid[k] <= rst_n;
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    int seq[16];
    seq = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    rst_n        = 1'b0;
    clr          = 1'b0;
    load         = 1'b0;
    load_is_gray = 1'b0;
    load_val     = '0;
    en           = 1'b0;
    up           = 1'b0;
    @(negedge clk);
    #1;

    checkOutput("rst bin_a", int'(bin_a), 0);
    checkOutput("rst gray_a", int'(gray_a), 0);
    checkOutput("rst wrap_a", int'(wrap_a), 0);
    checkOutput("rst sat_a", int'(sat_a), 0);
    checkOutput("rst bin_w", int'(bin_w), 'h155);
    checkOutput("rst gray_w", int'(gray_w), 'h1FF);
    rst_n = 1'b1;

    // Full up-count cycle with wrap on the 16th step.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b1);
      checkOutput($sformatf("up gray_a step %0d", i), int'(gray_a), seq[i % 16]);
      checkOutput($sformatf("up wrap_a step %0d", i), int'(wrap_a), int'(i == 16));
    end
    checkOutput("up bin_s held", int'(bin_s), 'hF);
    checkOutput("up sat_s", int'(sat_s), 1);

    // Down wrap from zero.
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    checkOutput("dn bin_a", int'(bin_a), 'hF);
    checkOutput("dn gray_a", int'(gray_a), 'h8);
    checkOutput("dn wrap_a", int'(wrap_a), 1);
    checkOutput("dn sat_s at zero", int'(sat_s), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    checkOutput("dn2 bin_a", int'(bin_a), 'hE);
    checkOutput("dn2 gray_a", int'(gray_a), 'h9);
    checkOutput("dn2 wrap_a", int'(wrap_a), 0);

    // Saturation at the top, held while idle, released by a down step.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b1);
      checkOutput("sat bin_s", int'(bin_s), 'hF);
      checkOutput("sat sat_s", int'(sat_s), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
    checkOutput("idle sat_s kept", int'(sat_s), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b0);
    checkOutput("unsat bin_s", int'(bin_s), 'hE);
    checkOutput("unsat sat_s", int'(sat_s), 0);

    // Gray and binary loads override a simultaneous count request.
    applyStimulus(1'b0, 1'b1, 1'b1, 10'hC, 1'b1, 1'b1);
    checkOutput("ldg bin_a", int'(bin_a), 'h8);
    checkOutput("ldg gray_a", int'(gray_a), 'hC);
    checkOutput("ldg bin_w", int'(bin_w), 'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h5, 1'b1, 1'b0);
    checkOutput("ldb bin_a", int'(bin_a), 'h5);
    checkOutput("ldb gray_a", int'(gray_a), 'h7);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0);
    checkOutput("ldg wide bin_w", int'(bin_w), 'h2AA);
    checkOutput("ldg wide bin_a", int'(bin_a), 'hA);

    // Clear wins over load and enable.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h9, 1'b0, 1'b0);
    checkOutput("pri pre bin_a", int'(bin_a), 'h9);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h9, 1'b1, 1'b1);
    checkOutput("pri bin_a", int'(bin_a), 0);
    checkOutput("pri gray_a", int'(gray_a), 0);
    checkOutput("pri wrap_a", int'(wrap_a), 0);

    // Asynchronous reset between edges while counting.
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b1);
    checkOutput("pre-rst bin_w", int'(bin_w), 'h2A2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async bin_w", int'(bin_w), 'h155);
    checkOutput("async gray_w", int'(gray_w), 'h1FF);
    checkOutput("async bin_a", int'(bin_a), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b1);
    checkOutput("resume bin_w", int'(bin_w), 'h156);
    checkOutput("resume gray_w", int'(gray_w), 'h1FD);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
